// File: rtl/exu_alu_issue.sv
// ALU issue/writeback wrapper for the LA64 integer pipe: 2-entry skid buffer,
// operand select with result forwarding, execute-stage tracking and a 2-entry writeback queue.
`ifndef LA64_DATA_WIDTH
`define LA64_DATA_WIDTH 64
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 14
`endif

module exu_alu_issue (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [`ALU_OP_WIDTH-1:0]    in_alu_op,
    input  logic [4:0]                  in_rj,
    input  logic [4:0]                  in_rk,
    input  logic [4:0]                  in_rd,
    input  logic [`LA64_DATA_WIDTH-1:0] in_rj_data,
    input  logic [`LA64_DATA_WIDTH-1:0] in_rk_data,
    input  logic [`LA64_DATA_WIDTH-1:0] in_imm,
    input  logic [`LA64_DATA_WIDTH-1:0] in_pc,
    input  logic                        in_src0_is_pc,
    input  logic                        in_src1_is_imm,
    input  logic                        in_rf_we,
    output logic [`ALU_OP_WIDTH-1:0]    alu_op,
    output logic [`LA64_DATA_WIDTH-1:0] src0,
    output logic [`LA64_DATA_WIDTH-1:0] src1,
    input  logic [`LA64_DATA_WIDTH-1:0] alu_result,
    output logic                        wb_valid,
    input  logic                        wb_ready,
    output logic                        wb_we,
    output logic [4:0]                  wb_rd,
    output logic [`LA64_DATA_WIDTH-1:0] wb_data
);
    localparam int DW = `LA64_DATA_WIDTH;
    localparam int OW = `ALU_OP_WIDTH;

    typedef struct packed {
        logic [OW-1:0] op;
        logic [4:0]    rj;
        logic [4:0]    rk;
        logic [4:0]    rd;
        logic [DW-1:0] rj_data;
        logic [DW-1:0] rk_data;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
        logic          src0_is_pc;
        logic          src1_is_imm;
        logic          rf_we;
    } ibuf_entry_t;

    typedef struct packed {
        logic          we;
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } wbq_entry_t;

    ibuf_entry_t ibuf [2];
    logic        ibuf_rd_ptr, ibuf_wr_ptr;
    logic [1:0]  ibuf_count;
    wbq_entry_t  wbq [2];
    logic        wbq_rd_ptr, wbq_wr_ptr;
    logic [1:0]  wbq_count;
    logic        ex_valid, ex_we;
    logic [4:0]  ex_rd;

    ibuf_entry_t head, in_entry;
    wbq_entry_t  wbq_head, wbq_newest;
    logic        head_valid, enq, issue, wb_pop, wb_fire, wb_push;
    logic [2:0]  wbq_level;

    // Priority: execute stage, newest queued result, oldest queued result, stored data.
    function automatic logic [DW-1:0] fwd(
        input logic [4:0] r, input logic [DW-1:0] stored,
        input logic ex_hit, input logic [4:0] ex_r, input logic [DW-1:0] ex_d,
        input logic new_v, input wbq_entry_t new_e,
        input logic old_v, input wbq_entry_t old_e);
        fwd = stored;
        if (r != 5'd0) begin
            if (ex_hit && ex_r == r)                     fwd = ex_d;
            else if (new_v && new_e.we && new_e.rd == r) fwd = new_e.data;
            else if (old_v && old_e.we && old_e.rd == r) fwd = old_e.data;
        end
    endfunction

    assign head       = ibuf[ibuf_rd_ptr];
    assign head_valid = (ibuf_count != 2'd0);
    assign in_ready   = (ibuf_count < 2'd2);
    assign enq        = in_valid & in_ready & ~flush;

    assign wbq_head   = wbq[wbq_rd_ptr];
    assign wbq_newest = wbq[~wbq_wr_ptr];
    assign wb_valid   = (wbq_count != 2'd0);
    assign wb_we      = wb_valid & wbq_head.we;
    assign wb_rd      = wb_valid ? wbq_head.rd : 5'd0;
    assign wb_data    = wb_valid ? wbq_head.data : '0;
    assign wb_pop     = wb_valid & wb_ready;
    assign wb_fire    = wb_pop & wb_we & (wb_rd != 5'd0);
    assign wb_push    = ex_valid & ~flush;

    // Occupancy the WBQ will have after this edge if the head issues now.
    assign wbq_level = {1'b0, wbq_count} + {2'b00, ex_valid} - {2'b00, wb_pop};
    assign issue     = head_valid & ~flush & (wbq_level < 3'd2);

    // NOTE: always_comb gives every output a default first so no path infers a latch.
    always_comb begin
        in_entry             = '0;
        in_entry.op          = in_alu_op;
        in_entry.rj          = in_rj;
        in_entry.rk          = in_rk;
        in_entry.rd          = in_rd;
        in_entry.rj_data     = (wb_fire && in_rj == wb_rd) ? wb_data : in_rj_data;
        in_entry.rk_data     = (wb_fire && in_rk == wb_rd) ? wb_data : in_rk_data;
        in_entry.imm         = in_imm;
        in_entry.pc          = in_pc;
        in_entry.src0_is_pc  = in_src0_is_pc;
        in_entry.src1_is_imm = in_src1_is_imm;
        in_entry.rf_we       = in_rf_we;
    end

    always_comb begin
        alu_op = issue ? head.op : '0;
        src0   = head.src0_is_pc ? head.pc
               : fwd(head.rj, head.rj_data, ex_valid & ex_we, ex_rd, alu_result,
                     wbq_count == 2'd2, wbq_newest, wb_valid, wbq_head);
        src1   = head.src1_is_imm ? head.imm
               : fwd(head.rk, head.rk_data, ex_valid & ex_we, ex_rd, alu_result,
                     wbq_count == 2'd2, wbq_newest, wb_valid, wbq_head);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ibuf_count  <= 2'd0;
            ibuf_rd_ptr <= 1'b0;
            ibuf_wr_ptr <= 1'b0;
            ex_valid    <= 1'b0;
            ex_we       <= 1'b0;
            ex_rd       <= 5'd0;
            wbq_count   <= 2'd0;
            wbq_rd_ptr  <= 1'b0;
            wbq_wr_ptr  <= 1'b0;
        end else begin
            if (flush) begin
                ibuf_count  <= 2'd0;
                ibuf_rd_ptr <= 1'b0;
                ibuf_wr_ptr <= 1'b0;
            end else begin
                ibuf_count <= ibuf_count + {1'b0, enq} - {1'b0, issue};
                if (enq)   ibuf_wr_ptr <= ~ibuf_wr_ptr;
                if (issue) ibuf_rd_ptr <= ~ibuf_rd_ptr;
            end
            ex_valid  <= issue;
            ex_we     <= head.rf_we;
            ex_rd     <= head.rd;
            wbq_count <= wbq_count + {1'b0, wb_push} - {1'b0, wb_pop};
            if (wb_push) wbq_wr_ptr <= ~wbq_wr_ptr;
            if (wb_pop)  wbq_rd_ptr <= ~wbq_rd_ptr;
        end
    end

    // NOTE: entry storage has no reset; the counts alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wb_fire && ibuf[i].rj == wb_rd) ibuf[i].rj_data <= wb_data;
            if (wb_fire && ibuf[i].rk == wb_rd) ibuf[i].rk_data <= wb_data;
        end
        if (enq)     ibuf[ibuf_wr_ptr] <= in_entry;
        if (wb_push) wbq[wbq_wr_ptr]   <= '{we: ex_we, rd: ex_rd, data: alu_result};
    end

endmodule

// File: tb/tb_exu_alu_issue.sv
// Directed self-checking bench for exu_alu_issue: a 1-cycle ALU model plus a scoreboard
// of expected writebacks popped whenever the DUT completes a writeback handshake.
`ifndef LA64_DATA_WIDTH
`define LA64_DATA_WIDTH 64
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 14
`endif

module tb_exu_alu_issue;
    localparam logic [13:0] OP_ADD = 14'h0001;
    localparam logic [13:0] OP_OR  = 14'h0040;
    localparam logic [13:0] OP_LUI = 14'h2000;
    localparam logic [63:0] STALE  = 64'h0000_0000_0000_BAD0;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_exp_t;

    logic        clk, rst_n, flush, in_valid, in_ready;
    logic [13:0] in_alu_op, alu_op;
    logic [4:0]  in_rj, in_rk, in_rd, wb_rd;
    logic [63:0] in_rj_data, in_rk_data, in_imm, in_pc, src0, src1, alu_result, wb_data;
    logic        in_src0_is_pc, in_src1_is_imm, in_rf_we;
    logic        wb_valid, wb_ready, wb_we;

    wb_exp_t sb[$];
    int      total = 0;
    int      bad   = 0;

    exu_alu_issue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
        .in_rj(in_rj), .in_rk(in_rk), .in_rd(in_rd),
        .in_rj_data(in_rj_data), .in_rk_data(in_rk_data),
        .in_imm(in_imm), .in_pc(in_pc),
        .in_src0_is_pc(in_src0_is_pc), .in_src1_is_imm(in_src1_is_imm), .in_rf_we(in_rf_we),
        .alu_op(alu_op), .src0(src0), .src1(src1), .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: registers its inputs, so results appear one cycle after issue.
    always @(posedge clk) begin
        case (alu_op)
            OP_ADD:  alu_result <= src0 + src1;
            OP_OR:   alu_result <= src0 | src1;
            OP_LUI:  alu_result <= src1;
            default: alu_result <= 64'd0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_valid === 1'b1 && wb_ready === 1'b1) begin
            check("wb_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                wb_exp_t e;
                e = sb.pop_front();
                check("wb_we", 64'(wb_we), 64'(e.we));
                check("wb_rd", 64'(wb_rd), 64'(e.rd));
                check("wb_data", wb_data, e.data);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [13:0] op, input logic [4:0] rj, input logic [4:0] rk,
                          input logic [4:0] rd, input logic [63:0] rjd, input logic [63:0] rkd,
                          input logic [63:0] imm, input logic [63:0] pc,
                          input logic s0pc, input logic s1imm, input logic we);
        in_valid       = 1'b1;
        in_alu_op      = op;
        in_rj          = rj;
        in_rk          = rk;
        in_rd          = rd;
        in_rj_data     = rjd;
        in_rk_data     = rkd;
        in_imm         = imm;
        in_pc          = pc;
        in_src0_is_pc  = s0pc;
        in_src1_is_imm = s1imm;
        in_rf_we       = we;
    endtask

    task automatic send(input logic [13:0] op, input logic [4:0] rj, input logic [4:0] rk,
                        input logic [4:0] rd, input logic [63:0] rjd, input logic [63:0] rkd,
                        input logic [63:0] imm, input logic [63:0] pc,
                        input logic s0pc, input logic s1imm, input logic we,
                        input logic [63:0] exp_data, input bit track);
        int n = 0;
        wb_exp_t e;
        set_op(op, rj, rk, rd, rjd, rkd, imm, pc, s0pc, s1imm, we);
        while (in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("send_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        e.we   = we;
        e.rd   = rd;
        e.data = exp_data;
        if (track) sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check(tag, 64'(sb.size()), 64'd0);
        check({tag, "_idle"}, 64'(wb_valid), 64'd0);
    endtask

    initial begin
        int acc_cnt;
        logic acc_now;
        rst_n = 1'b0;
        flush = 1'b0;
        wb_ready = 1'b1;
        set_op(14'd0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'd0);
        check("rst_wb_we", 64'(wb_we), 64'd0);
        check("rst_wb_rd", 64'(wb_rd), 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        rst_n = 1'b1;
        tick();

        // Dependent chain: r1 = r0 + 5; r2 = r1 + r1 issued back-to-back
        send(OP_ADD, 5'd0, 5'd0, 5'd1, 64'd0, 64'd0, 64'd5, 64'd0, 1'b0, 1'b1, 1'b1, 64'd5, 1'b1);
        check("chain_i1_op", 64'(alu_op), 64'(OP_ADD));
        check("chain_i1_src1", src1, 64'd5);
        send(OP_ADD, 5'd1, 5'd1, 5'd2, STALE, STALE, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 64'd10, 1'b1);
        check("chain_i2_op", 64'(alu_op), 64'(OP_ADD));
        check("chain_i2_src0", src0, 64'd5);
        check("chain_i2_src1", src1, 64'd5);
        tick();
        check("chain_wb1_valid", 64'(wb_valid), 64'd1);
        check("chain_wb1_rd", 64'(wb_rd), 64'd1);
        check("chain_wb1_data", wb_data, 64'd5);
        tick();
        check("chain_wb2_rd", 64'(wb_rd), 64'd2);
        check("chain_wb2_data", wb_data, 64'd10);
        drain("chain_drain");

        // Snoop: OR r4 = r3 | r0 held in the skid buffer while r3 writes back
        wb_ready = 1'b0;
        send(OP_ADD, 5'd0, 5'd0, 5'd3, 64'd0, 64'd0, 64'h1234, 64'd0, 1'b0, 1'b1, 1'b1, 64'h1234, 1'b1);
        send(OP_ADD, 5'd0, 5'd0, 5'd5, 64'd0, 64'd0, 64'h55, 64'd0, 1'b0, 1'b1, 1'b1, 64'h55, 1'b1);
        send(OP_ADD, 5'd0, 5'd0, 5'd6, 64'd0, 64'd0, 64'h66, 64'd0, 1'b0, 1'b1, 1'b1, 64'h66, 1'b1);
        send(OP_OR, 5'd3, 5'd0, 5'd4, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 64'h1234, 1'b1);
        repeat (2) tick();
        check("snoop_stall_op", 64'(alu_op), 64'd0);
        check("snoop_in_ready", 64'(in_ready), 64'd0);
        check("snoop_wb_valid", 64'(wb_valid), 64'd1);
        wb_ready = 1'b1;
        drain("snoop_drain");

        // Backpressure: six ops offered back-to-back, only four fit
        wb_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            wb_exp_t e;
            set_op(OP_ADD, 5'd0, 5'd0, 5'(20 + i), 64'd0, 64'd0, 64'(256 + i), 64'd0,
                   1'b0, 1'b1, 1'b1);
            acc_now = in_ready;
            tick();
            if (acc_now) begin
                e.we   = 1'b1;
                e.rd   = 5'(20 + i);
                e.data = 64'(256 + i);
                sb.push_back(e);
                acc_cnt++;
            end
        end
        in_valid = 1'b0;
        check("bp_accepted", 64'(acc_cnt), 64'd4);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_wb_valid", 64'(wb_valid), 64'd1);
        check("bp_wb_head_rd", 64'(wb_rd), 64'd20);
        check("bp_stall_op", 64'(alu_op), 64'd0);
        wb_ready = 1'b1;
        drain("bp_drain");

        // Flush: X queued, A in execute, B buffered, C offered during flush
        wb_ready = 1'b0;
        send(OP_ADD, 5'd0, 5'd0, 5'd9, 64'd0, 64'd0, 64'h99, 64'd0, 1'b0, 1'b1, 1'b1, 64'h99, 1'b1);
        send(OP_ADD, 5'd0, 5'd0, 5'd10, 64'd0, 64'd0, 64'hAA, 64'd0, 1'b0, 1'b1, 1'b1, 64'hAA, 1'b0);
        check("flush_a_issue", 64'(alu_op), 64'(OP_ADD));
        set_op(OP_ADD, 5'd0, 5'd0, 5'd11, 64'd0, 64'd0, 64'hBB, 64'd0, 1'b0, 1'b1, 1'b1);
        tick();
        flush = 1'b1;
        set_op(OP_ADD, 5'd0, 5'd0, 5'd12, 64'd0, 64'd0, 64'hCC, 64'd0, 1'b0, 1'b1, 1'b1);
        check("flush_no_issue", 64'(alu_op), 64'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_wb_valid", 64'(wb_valid), 64'd1);
        check("flush_wb_rd", 64'(wb_rd), 64'd9);
        wb_ready = 1'b1;
        drain("flush_drain");

        // Operand select and forwarding exclusions
        send(OP_ADD, 5'd0, 5'd0, 5'd14, 64'd0, 64'd0, 64'h20, 64'h1000, 1'b1, 1'b1, 1'b1, 64'h1020, 1'b1);
        send(OP_LUI, 5'd0, 5'd0, 5'd15, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_F000, 64'd0,
             1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_F000, 1'b1);
        send(OP_ADD, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'h77, 64'd0, 1'b0, 1'b1, 1'b1, 64'h77, 1'b1);
        send(OP_ADD, 5'd0, 5'd0, 5'd16, 64'd0, 64'd0, 64'd1, 64'd0, 1'b0, 1'b1, 1'b1, 64'd1, 1'b1);
        send(OP_ADD, 5'd0, 5'd0, 5'd17, 64'd0, 64'd0, 64'd3, 64'd0, 1'b0, 1'b1, 1'b0, 64'd3, 1'b1);
        send(OP_ADD, 5'd17, 5'd0, 5'd18, 64'h40, 64'd0, 64'd1, 64'd0, 1'b0, 1'b1, 1'b1, 64'h41, 1'b1);
        drain("opsel_drain");

        // Reset mid-operation discards buffered and queued work
        wb_ready = 1'b0;
        send(OP_ADD, 5'd0, 5'd0, 5'd21, 64'd0, 64'd0, 64'h21, 64'd0, 1'b0, 1'b1, 1'b1, 64'h21, 1'b0);
        send(OP_ADD, 5'd0, 5'd0, 5'd22, 64'd0, 64'd0, 64'h22, 64'd0, 1'b0, 1'b1, 1'b1, 64'h22, 1'b0);
        repeat (2) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        check("mrst_in_ready", 64'(in_ready), 64'd1);
        check("mrst_wb_valid", 64'(wb_valid), 64'd0);
        check("mrst_alu_op", 64'(alu_op), 64'd0);
        rst_n = 1'b1;
        wb_ready = 1'b1;
        repeat (5) tick();
        check("mrst_after_wb_valid", 64'(wb_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
